// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode map, ALU
// function codes, FSM state encoding and the registered control bundle.
package cpu_ctrl_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned ALU_W = 2;

    // Opcode map (instr[15:12]); 0x8-0xE are illegal
    localparam logic [OP_W-1:0] OP_LD   = 4'h0;
    localparam logic [OP_W-1:0] OP_ST   = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
    localparam logic [OP_W-1:0] OP_AND  = 4'h4;
    localparam logic [OP_W-1:0] OP_OR   = 4'h5;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'h6;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h7;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    // ALU function codes
    localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALU_W-1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Control bundle driven to the datapath
    typedef struct packed {
        logic             ir_en;
        logic             pc_en;
        logic             beq;
        logic             mem_read;
        logic             mem_write;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             reg_write;
        logic             load;
        logic [ALU_W-1:0] alu_op;
        logic             illegal_op;
        logic             halted;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier.
// Ports:
//   i_op         opcode to classify
//   o_is_alu     ADD/SUB/AND/OR
//   o_is_mem     LD or ST
//   o_is_ld      LD
//   o_is_ldi     LDI
//   o_is_beq     BEQ
//   o_is_illegal 0x8-0xE
//   o_is_halt    HALT
//   o_alu        ALU function (SUB for BEQ, ADD for non-ALU ops)
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]  i_op,
    output logic             o_is_alu,
    output logic             o_is_mem,
    output logic             o_is_ld,
    output logic             o_is_ldi,
    output logic             o_is_beq,
    output logic             o_is_illegal,
    output logic             o_is_halt,
    output logic [ALU_W-1:0] o_alu
);

    always_comb begin
        o_is_alu     = 1'b0;
        o_is_mem     = 1'b0;
        o_is_ld      = 1'b0;
        o_is_ldi     = 1'b0;
        o_is_beq     = 1'b0;
        o_is_illegal = 1'b0;
        o_is_halt    = 1'b0;
        o_alu        = ALU_ADD;
        case (i_op)
            OP_LD: begin
                o_is_mem = 1'b1;
                o_is_ld  = 1'b1;
            end
            OP_ST:   o_is_mem = 1'b1;
            OP_ADD: begin
                o_is_alu = 1'b1;
                o_alu    = ALU_ADD;
            end
            OP_SUB: begin
                o_is_alu = 1'b1;
                o_alu    = ALU_SUB;
            end
            OP_AND: begin
                o_is_alu = 1'b1;
                o_alu    = ALU_AND;
            end
            OP_OR: begin
                o_is_alu = 1'b1;
                o_alu    = ALU_OR;
            end
            OP_BEQ: begin
                o_is_beq = 1'b1;
                o_alu    = ALU_SUB;
            end
            OP_LDI:  o_is_ldi  = 1'b1;
            OP_HALT: o_is_halt = 1'b1;
            default: o_is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 16-bit RISC core. Sequences each
// instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath
// control inputs. All outputs are registered, decoded from the next state.
// Optional feature macro: CTRL_MEM_WAIT_EN adds mem_ready and lets MEM stall.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   opcode       instr[15:12], sampled only in DECODE
//   mem_ready    data-memory done (CTRL_MEM_WAIT_EN only)
//   ir_en, pc_en, beq, mem_read, mem_write, reg_dst, mem_to_reg,
//   reg_write, load, alu_op       datapath controls
//   illegal_op   one-cycle pulse on unknown opcode
//   halted       sticky HALT indication, cleared only by reset
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  opcode,
`ifdef CTRL_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic             ir_en,
    output logic             pc_en,
    output logic             beq,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             load,
    output logic [ALU_W-1:0] alu_op,
    output logic             illegal_op,
    output logic             halted
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [OP_W-1:0] r_op_q;
    logic [OP_W-1:0] w_op;
    ctrl_t           r_ctrl;
    ctrl_t           w_ctrl_nxt;

    logic             w_is_alu;
    logic             w_is_mem;
    logic             w_is_ld;
    logic             w_is_ldi;
    logic             w_is_beq;
    logic             w_is_illegal;
    logic             w_is_halt;
    logic [ALU_W-1:0] w_alu;
    logic             w_mem_done;

    // In DECODE the opcode is still being latched, so the EXEC outputs must
    // be decoded from the live input rather than the stale op_q.
    assign w_op = (r_state == ST_DECODE) ? opcode : r_op_q;

    ctrl_decode u_decode (
        .i_op         (w_op),
        .o_is_alu     (w_is_alu),
        .o_is_mem     (w_is_mem),
        .o_is_ld      (w_is_ld),
        .o_is_ldi     (w_is_ldi),
        .o_is_beq     (w_is_beq),
        .o_is_illegal (w_is_illegal),
        .o_is_halt    (w_is_halt),
        .o_alu        (w_alu)
    );

`ifdef CTRL_MEM_WAIT_EN
    assign w_mem_done = mem_ready;
`else
    assign w_mem_done = 1'b1;
`endif

    // State, latched opcode and registered controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op_q  <= '0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= w_ctrl_nxt;
            if (r_state == ST_DECODE) begin
                r_op_q <= opcode;
            end
        end
    end

    // Next state, then the controls for the state being entered
    always_comb begin
        w_state_nxt = r_state;
        w_ctrl_nxt  = '0;

        case (r_state)
            ST_IDLE:   w_state_nxt = ST_FETCH;
            ST_FETCH:  w_state_nxt = ST_DECODE;
            ST_DECODE: w_state_nxt = w_is_halt ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (w_is_mem) begin
                    w_state_nxt = ST_MEM;
                end else if (w_is_alu || w_is_ldi) begin
                    w_state_nxt = ST_WB;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_MEM:  w_state_nxt = w_mem_done ? ST_WB : ST_MEM;
            ST_WB:   w_state_nxt = ST_FETCH;
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IDLE;
        endcase

        case (w_state_nxt)
            ST_FETCH: w_ctrl_nxt.ir_en = 1'b1;
            ST_EXEC: begin
                w_ctrl_nxt.alu_op = w_alu;
                // BEQ and illegal ops retire here
                if (w_is_beq) begin
                    w_ctrl_nxt.beq   = 1'b1;
                    w_ctrl_nxt.pc_en = 1'b1;
                end
                if (w_is_illegal) begin
                    w_ctrl_nxt.illegal_op = 1'b1;
                    w_ctrl_nxt.pc_en      = 1'b1;
                end
            end
            ST_MEM: begin
                w_ctrl_nxt.alu_op    = w_alu;
                w_ctrl_nxt.mem_read  = w_is_ld;
                w_ctrl_nxt.mem_write = w_is_mem && !w_is_ld;
            end
            ST_WB: begin
                w_ctrl_nxt.alu_op = w_alu;
                w_ctrl_nxt.pc_en  = 1'b1;
                if (w_is_alu) begin
                    w_ctrl_nxt.reg_write = 1'b1;
                    w_ctrl_nxt.reg_dst   = 1'b1;
                end
                if (w_is_ld) begin
                    w_ctrl_nxt.mem_read   = 1'b1;
                    w_ctrl_nxt.mem_to_reg = 1'b1;
                    w_ctrl_nxt.reg_write  = 1'b1;
                end
                if (w_is_ldi) begin
                    w_ctrl_nxt.load      = 1'b1;
                    w_ctrl_nxt.reg_write = 1'b1;
                end
            end
            ST_HALT: w_ctrl_nxt.halted = 1'b1;
            default: ;
        endcase
    end

    assign ir_en      = r_ctrl.ir_en;
    assign pc_en      = r_ctrl.pc_en;
    assign beq        = r_ctrl.beq;
    assign mem_read   = r_ctrl.mem_read;
    assign mem_write  = r_ctrl.mem_write;
    assign reg_dst    = r_ctrl.reg_dst;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign reg_write  = r_ctrl.reg_write;
    assign load       = r_ctrl.load;
    assign alu_op     = r_ctrl.alu_op;
    assign illegal_op = r_ctrl.illegal_op;
    assign halted     = r_ctrl.halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. The stimulus side builds
// the expected per-cycle control trace of each instruction from the opcode
// rules and queues it; a negedge monitor pops and compares every cycle.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       ir_en;
        logic       pc_en;
        logic       beq;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       load;
        logic [1:0] alu_op;
        logic       illegal_op;
        logic       halted;
    } ctl_t;

    localparam int HALT_CYC = 20;
`ifdef CTRL_MEM_WAIT_EN
    localparam int MAX_WAIT = 3;
`else
    localparam int MAX_WAIT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] opcode = 4'h0;
`ifdef CTRL_MEM_WAIT_EN
    logic       mem_ready = 1'b0;
`endif
    logic       ir_en, pc_en, beq, mem_read, mem_write, reg_dst;
    logic       mem_to_reg, reg_write, load, illegal_op, halted;
    logic [1:0] alu_op;

    ctl_t act;
    ctl_t exp_q[$];
    ctl_t tr_q[$];
    logic chk_en = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   pc_seen = 0;
    int   rw_seen = 0;
    int   pc_exp = 0;
    int   rw_exp = 0;

    multicycle_control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
`ifdef CTRL_MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .ir_en      (ir_en),
        .pc_en      (pc_en),
        .beq        (beq),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .load       (load),
        .alu_op     (alu_op),
        .illegal_op (illegal_op),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    assign act = {ir_en, pc_en, beq, mem_read, mem_write, reg_dst,
                  mem_to_reg, reg_write, load, alu_op, illegal_op, halted};

    // Monitor: one expected control word per clock cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (chk_en) begin
            if (pc_en)     pc_seen++;
            if (reg_write) rw_seen++;
            if (exp_q.size() > 0) begin
                ctl_t e;
                e = exp_q.pop_front();
                n_chk++;
                if (act !== e) begin
                    $display("FAIL ctrl_word cycle %0d: act=%b exp=%b", cyc, act, e);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic check_zero(input string name);
        n_chk++;
        if (act !== ctl_t'(0)) begin
            $display("FAIL %s: act=%b exp=0", name, act);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        n_chk++;
        if (a != e) begin
            $display("FAIL %s: act=%0d exp=%0d", name, a, e);
        end else begin
            n_pass++;
        end
    endtask

    // Expected cycle-by-cycle trace of one instruction, FETCH first
    function automatic void build_trace(input logic [3:0] op, input int w);
        ctl_t c;
        logic is_alu = (op >= 4'h2) && (op <= 4'h5);
        logic is_ld  = (op == 4'h0);
        logic is_st  = (op == 4'h1);
        logic is_beq = (op == 4'h6);
        logic is_ldi = (op == 4'h7);
        logic is_hlt = (op == 4'hF);
        logic is_ill = (op >= 4'h8) && (op <= 4'hE);
        logic [1:0] a = is_alu ? 2'(op - 4'h2) : (is_beq ? 2'b01 : 2'b00);
        tr_q.delete();
        c = '0; c.ir_en = 1'b1; tr_q.push_back(c);   // FETCH
        c = '0; tr_q.push_back(c);                   // DECODE
        if (is_hlt) begin
            c = '0; c.halted = 1'b1;
            for (int i = 0; i < HALT_CYC; i++) tr_q.push_back(c);
            return;
        end
        c = '0; c.alu_op = a;                        // EXEC
        if (is_beq) begin c.beq = 1'b1; c.pc_en = 1'b1; end
        if (is_ill) begin c.illegal_op = 1'b1; c.pc_en = 1'b1; end
        tr_q.push_back(c);
        if (is_ld || is_st) begin
            c = '0; c.alu_op = a; c.mem_read = is_ld; c.mem_write = is_st;
            for (int k = 0; k <= w; k++) tr_q.push_back(c);
        end
        if (is_alu || is_ld || is_st || is_ldi) begin
            c = '0; c.alu_op = a; c.pc_en = 1'b1;
            if (is_alu) begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            if (is_ld)  begin c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            if (is_ldi) begin c.load = 1'b1; c.reg_write = 1'b1; end
            tr_q.push_back(c);
        end
    endfunction

    // Issue one instruction; ncyc_max truncates it (used before an abort)
    task automatic run_instr(input logic [3:0] op, input int w, input int ncyc_max);
        int len;
        logic is_mem = (op == 4'h0) || (op == 4'h1);
        build_trace(op, w);
        len = (ncyc_max < tr_q.size()) ? ncyc_max : tr_q.size();
        for (int i = 0; i < len; i++) exp_q.push_back(tr_q[i]);
        if (len == tr_q.size() && op != 4'hF) begin
            pc_exp++;
            if (op == 4'h0 || (op >= 4'h2 && op <= 4'h5) || op == 4'h7) rw_exp++;
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            // Only the DECODE-cycle value may matter; everything else is noise
            opcode = (i == 1) ? op : 4'($urandom);
`ifdef CTRL_MEM_WAIT_EN
            if (is_mem && i >= 3 && i <= 3 + w) mem_ready = (i == 3 + w);
            else mem_ready = 1'($urandom);
`else
            if (is_mem && w != 0) $display("bench: waits ignored without mem_ready");
`endif
        end
    endtask

    // Asynchronous reset, checked immediately and while held
    task automatic do_reset();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_zero("reset_async");
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_zero("reset_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back(ctl_t'(0));                  // IDLE cycle
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2;
        do_reset();
        run_instr(4'h2, 0, 99);                      // ADD straight after reset
        run_instr(4'h6, 0, 99);                      // BEQ
        run_instr(4'h0, MAX_WAIT, 99);               // LD with waits when enabled
        run_instr(4'h1, 0, 99);                      // ST
        run_instr(4'h9, 0, 99);                      // illegal
        run_instr(4'h7, 0, 99);                      // LDI
        run_instr(4'hE, 0, 99);                      // illegal upper bound
        run_instr(4'h8, 0, 99);                      // illegal lower bound
        for (int n = 0; n < 40; n++) begin
            run_instr(4'($urandom_range(14, 0)), $urandom_range(MAX_WAIT, 0), 99);
        end
        run_instr(4'h2, 0, 3);                       // abort ADD in EXEC
        do_reset();
        run_instr(4'h0, MAX_WAIT, 4);                // abort LD in MEM
        do_reset();
        run_instr(4'h5, 0, 99);
        run_instr(4'hF, 0, 99);                      // HALT, held 20 cycles
        do_reset();                                  // reset out of HALT
        run_instr(4'h3, 0, 99);
        @(negedge clk);
        check_int("queue_drained", exp_q.size(), 0);
        check_int("pc_en_count", pc_seen, pc_exp);
        check_int("reg_write_count", rw_seen, rw_exp);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
